hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard controller for the five-stage MIPS core. It sits beside the ID stage and drives that stage's `Hazard`, `IFIDFlush`, `forward1` and `forward2` inputs. It decides load-use stalls, branch-operand stalls and ID-comparator forwarding, and flushes IF/ID on a taken branch or jump. A small FSM holds the two-cycle branch-after-load stall, and saturating counters record stall and flush activity.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters

Ports:
- clock  in  1  system clock; all state updates on its posedge
- reset  in  1  synchronous, active-high reset
- IDRs, IDRt  in  5 each  source register fields of the instruction in IF/ID
- IDUsesRs, IDUsesRt  in  1 each  instruction in ID reads Rs / Rt
- IDIsBranch  in  1  instruction in ID is beq/bne (compared in ID)
- IDBranch  in  1  ID comparator result: branch taken
- IDJump  in  1  instruction in ID is j
- IDEXMemRead, IDEXRegWrite  in  1 each  control bits of the instruction in EX
- IDEXDst  in  5  destination register of the instruction in EX (after RegDst mux)
- EXMEMMemRead, EXMEMRegWrite  in  1 each  control bits of the instruction in MEM
- EXMEMDst  in  5  destination register of the instruction in MEM
- Hazard  out  1  hold PC and IF/ID, insert a bubble into ID/EX
- IFIDFlush  out  1  zero IF/ID on the next edge
- forward1, forward2  out  1 each  ID comparator operand 1 / 2 takes EXMEMALUResultOut
- StallCount, FlushCount  out  CNT_W each  saturating event counters

## Operation
Match terms are combinational. A match requires the destination to be nonzero:
- mEX(r) = IDEXRegWrite & IDEXDst≠0 & IDEXDst==r
- mMEM(r) = EXMEMRegWrite & EXMEMDst≠0 & EXMEMDst==r
- srcEX = (IDUsesRs & mEX(IDRs)) | (IDUsesRt & mEX(IDRt)); srcMEM is the same expression built from mMEM.

Hazard classes, evaluated in state RUN:
- loadUse = IDEXMemRead & srcEX. Stall 1 cycle.
- brALU = IDIsBranch & srcEX & !IDEXMemRead. Stall 1 cycle.
- brLoadEX = IDIsBranch & srcEX & IDEXMemRead. Stall 2 cycles.
- brLoadMEM = IDIsBranch & srcMEM & EXMEMMemRead. Stall 1 cycle.

FSM states (state encoding lives in the package):
- RUN: Hazard = loadUse | brALU | brLoadEX | brLoadMEM. If brLoadEX, next state is HOLD; otherwise stay in RUN.
- HOLD: Hazard = 1 unconditionally. Next state is RUN.
- reset forces RUN from any state, including mid-stall.

Forwarding:
- forward1 = IDIsBranch & mMEM(IDRs) & !EXMEMMemRead & !Hazard
- forward2 = IDIsBranch & mMEM(IDRt) & !EXMEMMemRead & !Hazard
- EX-stage forwarding is out of scope; the EX forwarding unit handles it.

Flush:
- IFIDFlush = !Hazard & (IDJump | (IDIsBranch & IDBranch))
- A stalled branch never flushes, because its comparator operands are stale.

Counters:
- StallCount increments every cycle Hazard=1.
- FlushCount increments every cycle IFIDFlush=1.
- Both saturate at 2^CNT_W−1.

## Timing
- Hazard, IFIDFlush and forward* are combinational from the inputs and the current state, valid in the same cycle. The pipeline registers consume them at the next posedge.
- Reset values: state=RUN; StallCount=0; FlushCount=0. With all inputs 0, every output is 0.
- Load-use: 1 bubble. After that edge the load is in MEM and the dependency no longer matches in EX.
- Branch on ALU result: 1 stall cycle, then the following cycle asserts forward1 or forward2 from MEM.
- Branch on load in EX: exactly 2 Hazard cycles (RUN→HOLD→RUN). HOLD covers the load-in-MEM cycle, and brLoadMEM is not separately counted. In the cycle after HOLD the load is in WB, and the register file write-before-read supplies the value.
- Simultaneous events:
  - All hazard classes OR together.
  - Hazard has priority over flush and over forwarding.
  - HOLD ignores every input except reset.
- Register 0 never causes a stall or a forward.
- Counter saturation: the counter holds its value, with no wrap.

## Structure
- Package `hazard_pkg`: FSM state enum {RUN, HOLD}, constant REG_ZERO=5'd0, CNT_W default.
- One sub-module: `hazard_match`, a combinational comparator for (regwrite, dst, src, uses). It is instantiated once per match term.
- FSM and counters live in the top module. Target size is 150–250 lines.

## Test plan
- Reset: assert reset with arbitrary inputs for 2 cycles → all outputs 0, state RUN.
- Load-use: IDEXMemRead=1, IDEXRegWrite=1, IDEXDst=8, IDRs=8, IDUsesRs=1 → Hazard=1 for exactly 1 cycle; StallCount 0→1.
- Branch after ALU: IDIsBranch=1, IDRs=17, IDEXRegWrite=1, IDEXDst=17, then the same instruction moves to MEM (EXMEMDst=17) → Hazard for 1 cycle, then forward1=1 with Hazard=0. Repeat with IDRt=18 → forward2=1.
- Branch after load: lw $17 in EX, beq $17,$18 in ID → Hazard=1 for 2 cycles (RUN→HOLD→RUN), forward*=0, IFIDFlush=0 throughout. Assert reset during HOLD → next cycle in RUN with Hazard=0.
- Taken branch / jump: IDBranch=1 with IDIsBranch=1 and no hazard → IFIDFlush=1 for 1 cycle, FlushCount+1. IDJump=1 → IFIDFlush=1. Taken branch while Hazard=1 → IFIDFlush=0.
- Register 0 and saturation: IDEXDst=0, IDRs=0, IDEXMemRead=1 → Hazard=0. With CNT_W=2, hold a stall for 5 cycles → StallCount stops at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic {RUN, HOLD} state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: one producer/consumer register match, register 0 never matches
module hazard_match
  import hazard_pkg::*;
(
  input  logic       regwrite_i,
  input  logic [4:0] dst_i,
  input  logic [4:0] src_i,
  input  logic       uses_i,
  output logic       match_o
);
  assign match_o = uses_i & regwrite_i & (dst_i != REG_ZERO) & (dst_i == src_i);
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: ID-stage stall, branch-operand forwarding and IF/ID flush control
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       IDRs,
  input  logic [4:0]       IDRt,
  input  logic             IDUsesRs,
  input  logic             IDUsesRt,
  input  logic             IDIsBranch,
  input  logic             IDBranch,
  input  logic             IDJump,
  input  logic             IDEXMemRead,
  input  logic             IDEXRegWrite,
  input  logic [4:0]       IDEXDst,
  input  logic             EXMEMMemRead,
  input  logic             EXMEMRegWrite,
  input  logic [4:0]       EXMEMDst,
  output logic             Hazard,
  output logic             IFIDFlush,
  output logic             forward1,
  output logic             forward2,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;
  logic             src_ex, src_mem, load_use, br_alu, br_load_ex, br_load_mem;

  hazard_match u_ex_rs  (.regwrite_i(IDEXRegWrite),  .dst_i(IDEXDst),  .src_i(IDRs), .uses_i(IDUsesRs), .match_o(m_ex_rs));
  hazard_match u_ex_rt  (.regwrite_i(IDEXRegWrite),  .dst_i(IDEXDst),  .src_i(IDRt), .uses_i(IDUsesRt), .match_o(m_ex_rt));
  // MEM matches are kept without the uses gate because forwarding ignores it
  hazard_match u_mem_rs (.regwrite_i(EXMEMRegWrite), .dst_i(EXMEMDst), .src_i(IDRs), .uses_i(1'b1),     .match_o(m_mem_rs));
  hazard_match u_mem_rt (.regwrite_i(EXMEMRegWrite), .dst_i(EXMEMDst), .src_i(IDRt), .uses_i(1'b1),     .match_o(m_mem_rt));

  // hazard classes, stall decision, flush/forward gating and next-state values
  always_comb begin
    src_ex      = m_ex_rs | m_ex_rt;
    src_mem     = (IDUsesRs & m_mem_rs) | (IDUsesRt & m_mem_rt);
    load_use    = IDEXMemRead & src_ex;
    br_alu      = IDIsBranch & src_ex & ~IDEXMemRead;
    br_load_ex  = IDIsBranch & src_ex & IDEXMemRead;
    br_load_mem = IDIsBranch & src_mem & EXMEMMemRead;
    Hazard      = (state_q == HOLD) | load_use | br_alu | br_load_ex | br_load_mem;
    IFIDFlush   = ~Hazard & (IDJump | (IDIsBranch & IDBranch));
    forward1    = IDIsBranch & m_mem_rs & ~EXMEMMemRead & ~Hazard;
    forward2    = IDIsBranch & m_mem_rt & ~EXMEMMemRead & ~Hazard;
    state_d     = (state_q == RUN && br_load_ex) ? HOLD : RUN;
    stall_d     = (Hazard && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    flush_d     = (IFIDFlush && flush_q != '1) ? flush_q + 1'b1 : flush_q;
  end

  // FSM state and saturating activity counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign StallCount = stall_q;
  assign FlushCount = flush_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed checks of stalls, forwarding, flush and counters
module tb_hazard_controller;
  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] IDRs, IDRt, IDEXDst, EXMEMDst;
  logic       IDUsesRs, IDUsesRt, IDIsBranch, IDBranch, IDJump;
  logic       IDEXMemRead, IDEXRegWrite, EXMEMMemRead, EXMEMRegWrite;
  logic       Hazard, IFIDFlush, forward1, forward2;
  logic       Hazard2, IFIDFlush2, forward1_2, forward2_2;
  logic [15:0] StallCount, FlushCount;
  logic [1:0]  StallCount2, FlushCount2;
  int n_run = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  hazard_controller dut (
    .clock(clock), .reset(reset), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDIsBranch(IDIsBranch), .IDBranch(IDBranch), .IDJump(IDJump), .IDEXMemRead(IDEXMemRead),
    .IDEXRegWrite(IDEXRegWrite), .IDEXDst(IDEXDst), .EXMEMMemRead(EXMEMMemRead),
    .EXMEMRegWrite(EXMEMRegWrite), .EXMEMDst(EXMEMDst), .Hazard(Hazard), .IFIDFlush(IFIDFlush),
    .forward1(forward1), .forward2(forward2), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  hazard_controller #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDIsBranch(IDIsBranch), .IDBranch(IDBranch), .IDJump(IDJump), .IDEXMemRead(IDEXMemRead),
    .IDEXRegWrite(IDEXRegWrite), .IDEXDst(IDEXDst), .EXMEMMemRead(EXMEMMemRead),
    .EXMEMRegWrite(EXMEMRegWrite), .EXMEMDst(EXMEMDst), .Hazard(Hazard2), .IFIDFlush(IFIDFlush2),
    .forward1(forward1_2), .forward2(forward2_2), .StallCount(StallCount2), .FlushCount(FlushCount2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic h, input logic fl, input logic f1, input logic f2);
    #2;
    chk({tag, ".haz"}, {31'd0, Hazard}, {31'd0, h});
    chk({tag, ".flush"}, {31'd0, IFIDFlush}, {31'd0, fl});
    chk({tag, ".fwd1"}, {31'd0, forward1}, {31'd0, f1});
    chk({tag, ".fwd2"}, {31'd0, forward2}, {31'd0, f2});
    chk({tag, ".haz2"}, {31'd0, Hazard2}, {31'd0, h});
  endtask

  task automatic cnts(input string tag, input int s, input int f, input int s2, input int f2);
    chk({tag, ".stall"}, {16'd0, StallCount}, s);
    chk({tag, ".flushcnt"}, {16'd0, FlushCount}, f);
    chk({tag, ".stall2"}, {30'd0, StallCount2}, s2);
    chk({tag, ".flushcnt2"}, {30'd0, FlushCount2}, f2);
  endtask

  task automatic clr();
    IDRs = 0; IDRt = 0; IDEXDst = 0; EXMEMDst = 0;
    IDUsesRs = 0; IDUsesRt = 0; IDIsBranch = 0; IDBranch = 0; IDJump = 0;
    IDEXMemRead = 0; IDEXRegWrite = 0; EXMEMMemRead = 0; EXMEMRegWrite = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clr();
    reset = 1;
    IDRs = 5'd3; IDUsesRs = 1; IDIsBranch = 1; IDBranch = 1; IDJump = 1;
    IDEXMemRead = 1; IDEXRegWrite = 1; IDEXDst = 5'd3;
    tick(); tick();
    clr();
    outs("reset", 0, 0, 0, 0);
    cnts("reset", 0, 0, 0, 0);
    reset = 0;
    tick();
    outs("idle", 0, 0, 0, 0);
    cnts("idle", 0, 0, 0, 0);
    clr(); IDEXMemRead = 1; IDEXRegWrite = 1; IDEXDst = 5'd8; IDRs = 5'd8; IDUsesRs = 1;
    outs("lduse", 1, 0, 0, 0);
    tick();
    cnts("lduse", 1, 0, 1, 0);
    clr(); IDRs = 5'd8; IDUsesRs = 1; EXMEMMemRead = 1; EXMEMRegWrite = 1; EXMEMDst = 5'd8;
    outs("lduse_after", 0, 0, 0, 0);
    tick();
    cnts("lduse_after", 1, 0, 1, 0);
    clr(); IDIsBranch = 1; IDRs = 5'd17; IDRt = 5'd18; IDUsesRs = 1; IDUsesRt = 1;
    IDEXRegWrite = 1; IDEXDst = 5'd17;
    outs("bralu_rs", 1, 0, 0, 0);
    tick();
    cnts("bralu_rs", 2, 0, 2, 0);
    IDEXRegWrite = 0; IDEXDst = 0; EXMEMRegWrite = 1; EXMEMDst = 5'd17;
    outs("fwd_rs", 0, 0, 1, 0);
    tick();
    IDEXRegWrite = 1; IDEXDst = 5'd18; EXMEMRegWrite = 0; EXMEMDst = 0;
    outs("bralu_rt", 1, 0, 0, 0);
    tick();
    cnts("bralu_rt", 3, 0, 3, 0);
    IDEXRegWrite = 0; IDEXDst = 0; EXMEMRegWrite = 1; EXMEMDst = 5'd18;
    outs("fwd_rt", 0, 0, 0, 1);
    tick();
    clr(); IDIsBranch = 1; IDBranch = 1; IDRs = 5'd17; IDRt = 5'd18; IDUsesRs = 1; IDUsesRt = 1;
    IDEXMemRead = 1; IDEXRegWrite = 1; IDEXDst = 5'd17;
    outs("brload1", 1, 0, 0, 0);
    tick();
    cnts("brload1", 4, 0, 3, 0);
    clr(); IDJump = 1;
    outs("hold", 1, 0, 0, 0);
    tick();
    cnts("hold", 5, 0, 3, 0);
    clr();
    outs("after_hold", 0, 0, 0, 0);
    tick();
    cnts("after_hold", 5, 0, 3, 0);
    IDIsBranch = 1; IDRs = 5'd9; IDUsesRs = 1; IDEXMemRead = 1; IDEXRegWrite = 1; IDEXDst = 5'd9;
    tick();
    clr(); reset = 1;
    outs("rst_in_hold", 1, 0, 0, 0);
    tick();
    reset = 0;
    outs("rst_after", 0, 0, 0, 0);
    cnts("rst_after", 0, 0, 0, 0);
    IDIsBranch = 1; IDBranch = 1;
    outs("taken", 0, 1, 0, 0);
    tick();
    cnts("taken", 0, 1, 0, 1);
    clr(); IDJump = 1;
    outs("jump", 0, 1, 0, 0);
    tick();
    cnts("jump", 0, 2, 0, 2);
    clr(); IDIsBranch = 1; IDBranch = 1; IDRs = 5'd5; IDUsesRs = 1; IDEXRegWrite = 1; IDEXDst = 5'd5;
    outs("taken_stall", 1, 0, 0, 0);
    tick();
    cnts("taken_stall", 1, 2, 1, 2);
    clr(); IDIsBranch = 1; IDUsesRs = 1; IDUsesRt = 1; IDEXMemRead = 1; IDEXRegWrite = 1;
    EXMEMRegWrite = 1;
    outs("reg0", 0, 0, 0, 0);
    tick();
    cnts("reg0", 1, 2, 1, 2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
